// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: recovers a 32-bit word from a multiplexed active-low 7-segment bus.
module seg_frame_decoder #(
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [2:0]  which,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_digits,
  output logic        changed,
  output logic        stale,
  output logic [7:0]  seen
);
  localparam logic [1:0] SCAN = 2'd0, COMMIT = 2'd1, STALE = 2'd2;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] CODES [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [10:0]   prev;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          captured;
  logic [31:0]   shadow;
  logic [7:0]    shadow_err;
  logic [1:0]    state;
  logic          eq, cap, bad;
  logic [3:0]    nib;
  logic [7:0]    seen_n;
  assign eq = {which, seg} == prev;
  // capture lands on the SETTLE-th identical sample: count is SETTLE-2 before this increment
  assign cap = eq && !captured && cnt == CW'(SETTLE - 2);
  assign seen_n = (state == COMMIT ? 8'h00 : seen) | (8'b1 << which);
  always_comb begin
    nib = 4'h0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++)
      if (~seg[6:0] == CODES[i]) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= {3'd0, 8'hFF};
      cnt         <= '0;
      tcnt        <= '0;
      captured    <= 1'b0;
      shadow      <= '0;
      shadow_err  <= '0;
      state       <= SCAN;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_digits  <= '0;
      changed     <= 1'b0;
      stale       <= 1'b0;
      seen        <= '0;
    end else begin
      prev        <= {which, seg};
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      if (eq) cnt <= cnt == CW'(SETTLE) ? cnt : cnt + 1'b1;
      else begin
        cnt      <= '0;
        captured <= 1'b0;
      end
      tcnt <= cap ? '0 : tcnt == TW'(TIMEOUT) ? tcnt : tcnt + 1'b1;
      if (state == COMMIT) begin
        value       <= shadow;
        err_digits  <= shadow_err;
        frame_err   <= |shadow_err;
        frame_valid <= 1'b1;
        changed     <= shadow != value;
        seen        <= '0;
      end
      if (cap) begin
        captured                   <= 1'b1;
        shadow[{which, 2'b00} +: 4] <= nib;
        shadow_err[which]          <= bad;
        seen                       <= seen_n;
        stale                      <= 1'b0;
        state                      <= seen_n == 8'hFF ? COMMIT : SCAN;
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        state      <= STALE;
        stale      <= 1'b1;
        seen       <= '0;
        shadow     <= '0;
        shadow_err <= '0;
      end else if (state == COMMIT) state <= SCAN;
    end
  end
endmodule

// File: tb/tb_seg_frame_decoder.sv
// tb_seg_frame_decoder: scoreboard bench driving the multiplexed segment bus frame by frame.
module tb_seg_frame_decoder;
  localparam int TIMEOUT = 200;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  seg = 8'hFF;
  logic [2:0]  which = 3'd0;
  logic [31:0] value;
  logic        frame_valid, frame_err, changed, stale;
  logic [7:0]  err_digits, seen;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] v; logic [7:0] e; logic c;} exp_t;
  exp_t sb[$];
  logic [31:0] exp_last = '0;
  logic fv_prev = 1'b0;

  seg_frame_decoder #(.SETTLE(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg(seg), .which(which), .value(value),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_digits(err_digits),
    .changed(changed), .stale(stale), .seen(seen)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [6:0] p;
    p = 7'h00;
    case (n)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; 4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return {1'b1, ~p};
  endfunction

  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      exp_t x;
      total++;
      if (fv_prev) begin
        bad++;
        $display("FAIL fv_width frame_valid high two cycles in a row");
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame value=%h err=%h", value, err_digits);
      end else begin
        x = sb.pop_front();
        if (value !== x.v || err_digits !== x.e || frame_err !== (|x.e) || changed !== x.c) begin
          bad++;
          $display("FAIL frame got v=%h e=%h fe=%b ch=%b want v=%h e=%h fe=%b ch=%b",
                   value, err_digits, frame_err, changed, x.v, x.e, |x.e, x.c);
        end
      end
    end
    fv_prev = frame_valid;
  end

  task automatic show(input logic [2:0] w, input logic [7:0] s, input int dwell);
    which = w;
    seg = s;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [31:0] v, input logic [7:0] e);
    exp_t x;
    x.v = v;
    x.e = e;
    x.c = v !== exp_last;
    exp_last = v;
    sb.push_back(x);
  endtask

  task automatic wait_commit(input logic [31:0] v);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL commit_missing frame=%h pending=%0d required=0", v, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input logic [7:0] blank, input int dwell);
    logic [31:0] ev;
    ev = v;
    for (int k = 0; k < 8; k++) if (blank[k]) ev[4*k +: 4] = 4'h0;
    expect_frame(ev, blank);
    for (int k = 7; k >= 0; k--) show(3'(k), blank[k] ? 8'hFF : enc(v[4*k +: 4]), dwell);
    wait_commit(v);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    which = 3'd0;
    seg = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_last = '0;
    total++;
    if ({value, frame_valid, frame_err, err_digits, changed, stale, seen} !== '0) begin
      bad++;
      $display("FAIL reset_state v=%h fv=%b fe=%b ed=%h ch=%b st=%b seen=%h required all 0",
               value, frame_valid, frame_err, err_digits, changed, stale, seen);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    pulse_reset();
  endtask

  task automatic test_basic();
    send_frame(32'h12345678, 8'h00, 10);
    send_frame(32'h12345678, 8'h00, 10);
  endtask

  task automatic test_dwell();
    for (int k = 7; k >= 0; k--) show(3'(k), enc(4'(k)), 3);
    total++;
    if (seen !== 8'h00) begin
      bad++;
      $display("FAIL short_dwell seen=%h required=00", seen);
    end
    send_frame(32'hA0B1C2D3, 8'h00, 4);
  endtask

  task automatic test_blank();
    send_frame(32'h13579BDF, 8'h04, 10);
    total++;
    if (frame_err !== 1'b1 || value[11:8] !== 4'h0) begin
      bad++;
      $display("FAIL blank_digit fe=%b nib=%h required fe=1 nib=0", frame_err, value[11:8]);
    end
  endtask

  task automatic test_last_wins();
    logic [31:0] v;
    v = 32'hFEDCBA9A;
    expect_frame(v, 8'h00);
    show(3'd0, enc(4'h3), 6);
    for (int k = 7; k >= 2; k--) show(3'(k), enc(v[4*k +: 4]), 6);
    show(3'd0, enc(4'hA), 6);
    total++;
    if (seen !== 8'hFD) begin
      bad++;
      $display("FAIL last_wins_seen seen=%h required=FD", seen);
    end
    show(3'd1, enc(v[7:4]), 6);
    wait_commit(v);
  endtask

  task automatic test_stale();
    logic [31:0] p, v;
    p = 32'h77777777;
    v = 32'h0F1E2D3C;
    for (int k = 7; k >= 2; k--) show(3'(k), enc(p[4*k +: 4]), 6);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    total++;
    if (stale !== 1'b1 || seen !== 8'h00 || value !== exp_last) begin
      bad++;
      $display("FAIL stale_entry st=%b seen=%h v=%h required st=1 seen=00 v=%h", stale, seen, value, exp_last);
    end
    expect_frame(v, 8'h00);
    show(3'd7, enc(v[31:28]), 10);
    total++;
    if (stale !== 1'b0 || seen !== 8'h80) begin
      bad++;
      $display("FAIL stale_exit st=%b seen=%h required st=0 seen=80", stale, seen);
    end
    for (int k = 6; k >= 0; k--) show(3'(k), enc(v[4*k +: 4]), 10);
    wait_commit(v);
  endtask

  task automatic test_mid_reset();
    logic [31:0] g;
    g = 32'h11111111;
    for (int k = 0; k < 7; k++) show(3'(k), enc(g[4*k +: 4]), 6);
    total++;
    if (seen !== 8'h7F) begin
      bad++;
      $display("FAIL partial_seen seen=%h required=7F", seen);
    end
    pulse_reset();
    send_frame(32'hDEADBEEF, 8'h00, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell();
    test_blank();
    test_last_wins();
    test_stale();
    test_mid_reset();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_frame_decoder.md
Name: seg_frame_decoder

Overview:
- Receive-side counterpart of the board's multiplexed 7-segment driver.
- Watches the `seg`/`which` bus, waits for each digit to settle, and decodes the segment pattern back to a hex nibble.
- Assembles the eight nibbles into a 32-bit word. Used on-board and in benches as a self-checker for display output of the ALU lab and its successors.

Parameters:
- SETTLE, 4, consecutive identical samples of {which,seg} required before a digit is captured (≥2).
- TIMEOUT, 1000000, cycles without any capture before `stale` asserts.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- seg  input  8  segment bus, active-low; seg[0]=a … seg[6]=g, seg[7]=dp (ignored)
- which  input  3  digit select; digit k carries value bits [4k+3:4k]; digit 7 is leftmost
- value  output  32  last committed frame
- frame_valid  output  1  one-cycle pulse when `value` updates
- frame_err  output  1  committed frame contained ≥1 undecodable digit (held until next commit)
- err_digits  output  8  per-digit undecodable flags of committed frame
- changed  output  1  one-cycle pulse, coincident with frame_valid, when new value ≠ previous value
- stale  output  1  no digit captured for TIMEOUT cycles
- seen  output  8  digits captured in the current partial frame (debug)

Behaviour:
- Reset (rst=1 at edge) sets all of the following, overriding any activity:
  - value=0, frame_valid=0, frame_err=0, err_digits=0, changed=0, stale=0, seen=0.
  - Previous-sample register = {which=0, seg=8'hFF}; settle count=0; captured flag=0; timeout count=0; shadow word and shadow err=0.
  - A partial frame in progress is discarded.
- Sampling and settle count (every cycle):
  - Compare {which,seg} with the previous sample, then update the previous sample.
  - Equal: settle count increments, saturating at SETTLE.
  - Different: settle count=0 and captured flag cleared.
- Capture:
  - Occurs when the settle count reaches SETTLE-1 with an equal sample and the captured flag is 0. The capture happens on the SETTLE-th consecutive identical sample.
  - Exactly one capture per dwell; the captured flag is set.
- Decode, using the active-high gfedcba code on ~seg[6:0]:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - Any other pattern, including blank: nibble=0 and the digit's shadow err bit=1. Otherwise the shadow err bit=0.
- On capture of digit k: shadow[4k+3:4k] = nibble; seen[k]=1.
  - A repeat capture of the same digit before commit overwrites it (last wins).
- Commit:
  - Occurs the cycle after a capture that makes seen==8'hFF.
  - value ← shadow; err_digits ← shadow err; frame_err ← |shadow err; frame_valid=1; changed = (shadow≠old value); seen ← 0.
  - frame_valid and changed last exactly one cycle.
  - A capture in the commit cycle counts toward the next frame.
- FSM states:
  - SCAN: default. Captures happen here; a completing capture moves the FSM to COMMIT.
  - COMMIT: one cycle, then back to SCAN.
  - STALE: entered when the timeout count reaches TIMEOUT.
    - Entering STALE sets stale=1 and discards the partial frame (seen=0, shadow=0).
    - The FSM stays in STALE until the next capture; that capture clears stale and is recorded as the first digit of a new frame.
- Timeout count: cleared on every capture; otherwise increments, saturating at TIMEOUT.
  - Capture and timeout in the same cycle: the capture wins and stale stays 0.
- value, err_digits and frame_err hold between commits; stale does not alter them.

Test Plan:
- Drive digits 7..0 showing "12345678" (e.g. digit 3 seg=8'hF9 for "5"? no: "5" is ~6D → 8'h92), each held 10 cycles → one frame_valid pulse, value=32'h12345678, frame_err=0, changed=1; repeat the same frame → frame_valid=1, changed=0.
- Hold each digit only SETTLE-1=3 cycles → no capture, seen stays 0, no frame_valid; raise dwell to 4 → captures occur.
- Full frame of valid digits with digit 2 blank (seg=8'hFF) → value[11:8]=0, err_digits=8'h04, frame_err=1.
- Six digits captured, then bus frozen mid-change for TIMEOUT cycles → stale=1, seen=0; resume a full scan → stale clears on first capture; a frame commits after 8 captures.
- Digit 0 captured as "3" then re-shown as "A" before frame completion → committed value[3:0]=4'hA.
- Assert rst for 1 cycle with seen=8'h7F → all outputs 0; a following full frame commits normally with no stale data.
